// File: rtl/t16_divider.sv
// Iterative restoring divider for the t16q execute stage: one quotient bit per clock,
// quotient/remainder and z/c/n/v flags registered when the operation completes.
module t16_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted on any rising edge where the block is in IDLE or
  // DONE; busy is high while it computes, and done is a one-cycle result-valid pulse.

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_orig;
  logic             sign_q;
  logic             sign_r;
  logic             div_zero;
  logic             ovf;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_in_mag;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  assign dbg_state = state;

  always_comb begin
    dvd_mag    = (signed_op && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    dvs_in_mag = (signed_op && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    // Shifted partial remainder needs one extra bit before the trial subtract.
    trial      = {rem_w, quo_w[WIDTH-1]} - {1'b0, dvs_mag};
    q_final    = sign_q ? (~quo_w + 1'b1) : quo_w;
    r_final    = sign_r ? (~rem_w + 1'b1) : rem_w;
    if (div_zero) begin
      q_final = ALL_ONES;
      r_final = dvd_orig;
    end else if (ovf) begin
      q_final = MIN_NEG;
      r_final = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rem_w     <= '0;
      quo_w     <= '0;
      dvs_mag   <= '0;
      dvd_orig  <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            quo_w    <= dvd_mag;
            rem_w    <= '0;
            dvs_mag  <= dvs_in_mag;
            dvd_orig <= dividend;
            sign_q   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r   <= signed_op & dividend[WIDTH-1];
            div_zero <= (divisor == '0);
            ovf      <= signed_op && (dividend == MIN_NEG) && (divisor == ALL_ONES);
            count    <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem_w <= trial[WIDTH-1:0];
            quo_w <= {quo_w[WIDTH-2:0], 1'b1};
          end else begin
            rem_w <= {rem_w[WIDTH-2:0], quo_w[WIDTH-1]};
            quo_w <= {quo_w[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= q_final;
          remainder <= r_final;
          flag_z    <= (q_final == '0);
          flag_c    <= div_zero;
          flag_n    <= q_final[WIDTH-1];
          flag_v    <= ovf & ~div_zero;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t16_divider.sv
// Directed bench for t16_divider: vector table of divides plus hand-written sequences
// for ignored start, back-to-back start and mid-operation reset.
module tb_t16_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         flag_z, flag_c, flag_n, flag_v;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [3:0]   f;  // {z, c, n, v}
  } vec_t;

  vec_t vecs[10];

  t16_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents operands with start for exactly one edge, then scrambles the inputs.
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    signed_op = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic [3:0] f);
    chk({tag, "_quotient"}, 32'(quotient), 32'(q));
    chk({tag, "_remainder"}, 32'(remainder), 32'(r));
    chk({tag, "_flags_zcnv"}, 32'({flag_z, flag_c, flag_n, flag_v}), 32'(f));
  endtask

  initial begin
    int cyc, bcnt;

    vecs[0] = '{1'b0, 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 4'b0000};
    vecs[1] = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 4'b0010};
    vecs[2] = '{1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 4'b0000};
    vecs[3] = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b0110};
    vecs[4] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 4'b0011};
    vecs[5] = '{1'b0, 16'h0005, 16'h000A, 16'h0000, 16'h0005, 4'b1000};
    vecs[6] = '{1'b1, 16'h8001, 16'h0000, 16'hFFFF, 16'h8001, 4'b0110};
    vecs[7] = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 4'b0010};
    vecs[8] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0010};
    vecs[9] = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 4'b1000};

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk_result("reset", 16'h0000, 16'h0000, 4'b0000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].s, vecs[i].a, vecs[i].b);
      wait_done(cyc, bcnt);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(W + 1));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(W + 1));
      chk_result($sformatf("v%0d", i), vecs[i].q, vecs[i].r, vecs[i].f);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_hold_q", i), 32'(quotient), 32'(vecs[i].q));
    end

    // A second start four cycles into an operation must be ignored.
    launch(1'b0, 16'd100, 16'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    signed_op = 1'b0; dividend = 16'd9; divisor = 16'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    chk("ignore_latency", 32'(cyc + 5), 32'(W + 1));
    chk_result("ignore", 16'd33, 16'd1, 4'b0000);

    // Start in the done cycle is accepted back-to-back.
    launch(1'b0, 16'd9, 16'd9);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(cyc, bcnt);
    chk("b2b_latency", 32'(cyc), 32'(W + 1));
    chk_result("b2b", 16'd1, 16'd0, 4'b0000);
    @(posedge clk);
    #1;

    // Reset in the middle of an operation clears everything.
    launch(1'b0, 16'd100, 16'd3);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk_result("midrst", 16'h0000, 16'h0000, 4'b0000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    launch(1'b0, 16'd6, 16'd3);
    wait_done(cyc, bcnt);
    chk("post_rst_latency", 32'(cyc), 32'(W + 1));
    chk_result("post_rst", 16'd2, 16'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
